reg_context_engine: RTL and testbench
=====================================

Name: reg_context_engine

Overview:
- Bus initiator for the 8 x 16-bit register file. Saves all registers to data memory on request (context save), or reloads them from memory (context restore).
- Drives the register file read-address/read-data pair and write-port, and a simple handshaked memory port.
- Sits beside the control unit. Used for interrupt entry/exit and for task-switch save/restore.

Parameters:
- DATA_W, 16, register and memory data width
- ADDR_W, 16, memory address width
- NUM_REGS, 8, number of registers walked (register index width 3)
- PRESERVE_SP, 1, when 1, restore skips register 2 (stack pointer) entirely

Ports:
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- saveReq  in  1  start save; sampled in IDLE only
- restoreReq  in  1  start restore; sampled in IDLE only
- baseAddr  in  ADDR_W  memory base address; latched when a request is accepted
- busy  out  1  high while a save or restore is in progress
- done  out  1  one-cycle pulse on completion
- regRead  out  3  register index to the register file read port 1
- regData  in  DATA_W  register file read data 1 (combinational from regRead)
- regWriteReg  out  3  register file write index
- regWriteData  out  DATA_W  register file write data
- regWrite  out  1  register file write enable
- memAddr  out  ADDR_W  memory address
- memWriteData  out  DATA_W  memory write data
- memWrite  out  1  memory write strobe
- memRead  out  1  memory read strobe
- memReadData  in  DATA_W  memory read data; valid when memReady is high
- memReady  in  1  memory acknowledge for the current strobe

Behaviour:
- All outputs are flop outputs. Values given per state are those present during that state.
- Reset (resetN low, asynchronous): state IDLE, index 0, all outputs 0.
- Reset mid-operation:
  - Aborts immediately.
  - No done pulse is produced.
  - Registers and memory already written are not rolled back.
- States: IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, DONE.
- IDLE:
  - saveReq=1: latch baseAddr, index=0, go to SAVE_RD.
  - Otherwise restoreReq=1: latch baseAddr, go to RST_RD with index=0.
  - If both requests are high, save wins.
- Requests are ignored in every state other than IDLE. Requests are level-sampled, so a request still high on return to IDLE starts a new operation.
- SAVE_RD:
  - regRead=index, busy=1.
  - regData is captured into the data holding register at the end of the cycle.
  - Go to SAVE_WR.
- SAVE_WR:
  - memAddr=base+index, memWriteData=captured, memWrite=1.
  - Hold all three stable until memReady is sampled high.
  - Then: if index==7 go to DONE, else index+1 and go to SAVE_RD.
- RST_RD:
  - memAddr=base+index, memRead=1, held until memReady is sampled high.
  - memReadData is captured on that edge.
  - Go to RST_WR.
- RST_WR:
  - regWriteReg=index, regWriteData=captured, regWrite=1 for exactly one cycle.
  - Then: if index==7 go to DONE, else advance index and go to RST_RD.
- PRESERVE_SP=1 on restore: the index advance skips 2 (1 -> 3). No memory read and no register write occur for r2.
- DONE: done=1, busy=0, all strobes 0, one cycle, then IDLE.
- memReady is ignored whenever neither strobe is asserted.
- memAddr = base+index, computed modulo 2^ADDR_W (wraps, no error).
- memWrite and memRead are never high together.
- regWrite is never high during a save.
- Latency with memReady tied 1:
  - Save: busy for 16 cycles; done in the 17th cycle after the accepting edge.
  - Restore: busy for 16 cycles with PRESERVE_SP=0, or 14 cycles with PRESERVE_SP=1; done in the following cycle.
- Each wait cycle (memReady low while a strobe is asserted) adds exactly one cycle.

Test Plan:
1. Reset: hold resetN=0 -> all outputs 0. Start a save, assert resetN=0 while on r3 -> strobes, busy and done all 0 immediately; after release, IDLE with no done pulse.
2. Save, memReady=1, base=0x0100, r0..r7=0x1110..0x1117 -> exactly 8 memWrite cycles at 0x0100..0x0107 with data 0x1110..0x1117; busy for 16 cycles; a single done pulse in cycle 17.
3. Restore, PRESERVE_SP=1, mem[0x0200+i]=0xA000+i -> 7 one-cycle regWrite pulses for r0,r1,r3..r7 with 0xA000+i; r2 stays 256; no memRead at 0x0202; done in cycle 15.
4. Save with memReady held low for 3 cycles on the r5 write -> memWrite, memAddr=base+5 and memWriteData held for 4 cycles; done in cycle 20.
5. Save with base=0xFFFC -> write addresses FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
6. saveReq and restoreReq high together in IDLE -> save performed, no memRead. A restoreReq pulsed while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/reg_context_engine.sv
// rtl/reg_context_engine.sv - register file context save/restore bus initiator
module reg_context_engine #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGS    = 8,
    parameter bit PRESERVE_SP = 1'b1
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              saveReq,
    input  logic              restoreReq,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        regRead,
    input  logic [DATA_W-1:0] regData,
    output logic [2:0]        regWriteReg,
    output logic [DATA_W-1:0] regWriteData,
    output logic              regWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              memReady
);

    typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, DONE} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [2:0] SP_IDX   = 3'd2;

    state_t              state, state_n;
    logic [2:0]          index, index_n;
    logic [ADDR_W-1:0]   base, base_n;
    logic [DATA_W-1:0]   hold, hold_n;

    logic                busy_n, done_n, reg_write_n, mem_write_n, mem_read_n;
    logic [2:0]          reg_read_n, reg_write_reg_n;
    logic [DATA_W-1:0]   reg_write_data_n, mem_write_data_n;
    logic [ADDR_W-1:0]   mem_addr_n;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            index        <= '0;
            base         <= '0;
            hold         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            regRead      <= '0;
            regWriteReg  <= '0;
            regWriteData <= '0;
            regWrite     <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            memWrite     <= 1'b0;
            memRead      <= 1'b0;
        end else begin
            state        <= state_n;
            index        <= index_n;
            base         <= base_n;
            hold         <= hold_n;
            busy         <= busy_n;
            done         <= done_n;
            regRead      <= reg_read_n;
            regWriteReg  <= reg_write_reg_n;
            regWriteData <= reg_write_data_n;
            regWrite     <= reg_write_n;
            memAddr      <= mem_addr_n;
            memWriteData <= mem_write_data_n;
            memWrite     <= mem_write_n;
            memRead      <= mem_read_n;
        end
    end

    always_comb begin
        state_n          = state;
        index_n          = index;
        base_n           = base;
        hold_n           = hold;
        busy_n           = 1'b0;
        done_n           = 1'b0;
        reg_read_n       = '0;
        reg_write_reg_n  = '0;
        reg_write_data_n = '0;
        reg_write_n      = 1'b0;
        mem_addr_n       = '0;
        mem_write_data_n = '0;
        mem_write_n      = 1'b0;
        mem_read_n       = 1'b0;

        case (state)
            IDLE: begin
                if (saveReq) begin
                    base_n  = baseAddr;
                    index_n = '0;
                    state_n = SAVE_RD;
                end else if (restoreReq) begin
                    base_n  = baseAddr;
                    index_n = '0;
                    state_n = RST_RD;
                end
            end
            SAVE_RD: begin
                hold_n  = regData;
                state_n = SAVE_WR;
            end
            SAVE_WR: begin
                if (memReady) begin
                    if (index == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        index_n = index + 3'd1;
                        state_n = SAVE_RD;
                    end
                end
            end
            RST_RD: begin
                if (memReady) begin
                    hold_n  = memReadData;
                    state_n = RST_WR;
                end
            end
            RST_WR: begin
                if (index == LAST_IDX) begin
                    state_n = DONE;
                end else begin
                    // Stack pointer is live across the switch, so its slot is never reloaded
                    if (PRESERVE_SP && (index == SP_IDX - 3'd1))
                        index_n = index + 3'd2;
                    else
                        index_n = index + 3'd1;
                    state_n = RST_RD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered
        case (state_n)
            SAVE_RD: begin
                busy_n     = 1'b1;
                reg_read_n = index_n;
            end
            SAVE_WR: begin
                busy_n           = 1'b1;
                mem_addr_n       = base_n + ADDR_W'(index_n);
                mem_write_data_n = hold_n;
                mem_write_n      = 1'b1;
            end
            RST_RD: begin
                busy_n     = 1'b1;
                mem_addr_n = base_n + ADDR_W'(index_n);
                mem_read_n = 1'b1;
            end
            RST_WR: begin
                busy_n           = 1'b1;
                reg_write_reg_n  = index_n;
                reg_write_data_n = hold_n;
                reg_write_n      = 1'b1;
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_context_engine.sv
// tb/tb_reg_context_engine.sv - scoreboard bench for reg_context_engine
module tb_reg_context_engine;

    localparam bit P_SP = 1'b1;
    localparam logic [1:0] K_MW = 2'd0, K_MR = 2'd1, K_RW = 2'd2, K_DN = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        saveReq = 1'b0, restoreReq = 1'b0;
    logic [15:0] baseAddr = '0;
    logic        busy, done, regWrite, memWrite, memRead;
    logic [2:0]  regRead, regWriteReg;
    logic [15:0] regData, regWriteData, memAddr, memWriteData;
    logic [15:0] memReadData = '0;
    logic        memReady = 1'b0;

    logic [15:0] rf [8];
    logic [15:0] mem [65536];
    ev_t         q [$];
    int          tests = 0, fails = 0, done_count = 0, stall_cnt = 0;
    int          stall_mode = 0, wait_left = 0;
    logic [15:0] stall_addr = '0;
    bit          in_txn = 0, save_mode = 0;

    always #5 clock = ~clock;

    assign regData = rf[regRead];

    reg_context_engine #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8), .PRESERVE_SP(P_SP)) dut (
        .clock(clock), .resetN(resetN), .saveReq(saveReq), .restoreReq(restoreReq),
        .baseAddr(baseAddr), .busy(busy), .done(done), .regRead(regRead), .regData(regData),
        .regWriteReg(regWriteReg), .regWriteData(regWriteData), .regWrite(regWrite),
        .memAddr(memAddr), .memWriteData(memWriteData), .memWrite(memWrite), .memRead(memRead),
        .memReadData(memReadData), .memReady(memReady)
    );

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic void check_ev(input string name, input ev_t act, input bit pop);
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected event got %0h expected none", name, act);
        end else begin
            if (q[0] !== act) begin
                fails++;
                $display("FAIL %s got %0h expected %0h", name, act, q[0]);
            end
            if (pop) void'(q.pop_front());
        end
    endfunction

    // Memory responder: stalls chosen per transaction, random ready when idle
    always @(posedge clock) begin
        #1;
        if (memWrite || memRead) begin
            if (!in_txn) begin
                in_txn = 1;
                if (stall_mode == 1) wait_left = $urandom_range(0, 2);
                else if (stall_mode == 2 && memWrite && memAddr == stall_addr) wait_left = 3;
                else wait_left = 0;
            end
            if (wait_left > 0) begin
                memReady = 1'b0;
                wait_left--;
                stall_cnt++;
            end else begin
                memReady = 1'b1;
                in_txn = 0;
            end
        end else begin
            memReady = 1'($urandom);
            in_txn = 0;
        end
        memReadData = memReady ? mem[memAddr] : 16'($urandom);
    end

    // Monitor: compares every observed transaction against the queued expectation
    always @(negedge clock) begin
        if (resetN) begin
            if (memWrite || memRead) begin
                check("strobe_overlap", 64'(memWrite & memRead), 64'd0);
                check_ev("mem_txn", {(memWrite ? K_MW : K_MR), memAddr,
                                     (memWrite ? memWriteData : 16'h0)}, memReady);
                if (memWrite && memReady) mem[memAddr] = memWriteData;
            end
            if (regWrite) begin
                check("regwrite_in_save", 64'(save_mode), 64'd0);
                check_ev("reg_write", {K_RW, 13'h0, regWriteReg, regWriteData}, 1'b1);
                rf[regWriteReg] = regWriteData;
            end
            if (done) begin
                check_ev("done", {K_DN, 32'h0}, 1'b1);
                done_count++;
            end
        end
    end

    task automatic push_model(input bit is_save, input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            if (is_save) begin
                q.push_back({K_MW, 16'(base + 16'(i)), rf[i]});
            end else if (!(P_SP && i == 2)) begin
                q.push_back({K_MR, 16'(base + 16'(i)), 16'h0});
                q.push_back({K_RW, 16'(i), mem[16'(base + 16'(i))]});
            end
        end
        q.push_back({K_DN, 32'h0});
    endtask

    task automatic run_op(input string name, input bit is_save, input bit both,
                          input logic [15:0] base, input int mode, input bit pulse_rst);
        int cyc, busy_cnt, want, dc0;
        bit seen;
        push_model(is_save | both, base);
        stall_cnt = 0;
        stall_mode = mode;
        save_mode = is_save | both;
        dc0 = done_count;
        @(negedge clock);
        baseAddr = base;
        saveReq = is_save | both;
        restoreReq = !is_save | both;
        busy_cnt = 0;
        seen = 0;
        cyc = 0;
        @(posedge clock);
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clock);
            if (c == 1) begin saveReq = 0; restoreReq = 0; end
            if (pulse_rst && c == 5) restoreReq = 1;
            if (pulse_rst && c == 6) restoreReq = 0;
            if (busy) busy_cnt++;
            if (done) begin seen = 1; cyc = c; end
        end
        want = (is_save | both) ? 17 : (P_SP ? 15 : 17);
        want += stall_cnt;
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s timeout waiting for done", name);
            q.delete();
        end else begin
            check({name, "_done_cycle"}, 64'(cyc), 64'(want));
            check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(want - 1));
        end
        repeat (3) @(negedge clock);
        check({name, "_idle_after"}, {62'h0, busy, done}, 64'd0);
        check({name, "_one_done"}, 64'(done_count - dc0), 64'd1);
        check({name, "_queue_empty"}, 64'(q.size()), 64'd0);
        save_mode = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7);
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, done, regRead, regWriteReg, regWriteData, regWrite,
                                memAddr, memWriteData[7:0], memWrite, memRead}, 64'd0);
        check("reset_outputs_wd", 64'(memWriteData), 64'd0);
        @(negedge clock);
        resetN = 1;

        // Abort a save in the middle of register 3
        push_model(1, 16'h0300);
        stall_mode = 0;
        save_mode = 1;
        @(negedge clock);
        baseAddr = 16'h0300; saveReq = 1;
        @(negedge clock);
        saveReq = 0;
        for (int c = 0; c < 50 && !(memWrite && memAddr == 16'h0303); c++) @(negedge clock);
        check("abort_reached_r3", {memWrite, memAddr}, {1'b1, 16'h0303});
        #2 resetN = 0;
        #1 check("abort_outputs", {memWrite, memRead, regWrite, busy, done}, 64'd0);
        q.delete();
        begin
            int dc0;
            dc0 = done_count;
            @(negedge clock);
            #2 resetN = 1;
            repeat (6) @(negedge clock);
            check("abort_no_done", 64'(done_count - dc0), 64'd0);
            check("abort_idle", {busy, memWrite, memRead}, 64'd0);
        end
        save_mode = 0;

        for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);
        run_op("save_basic", 1, 0, 16'h0100, 0, 0);
        for (int i = 0; i < 8; i++) check("save_mem", 64'(mem[16'h0100 + 16'(i)]), 64'(16'h1110 + 16'(i)));

        for (int i = 0; i < 8; i++) mem[16'h0200 + 16'(i)] = 16'hA000 + 16'(i);
        rf[2] = 16'd256;
        run_op("restore_sp", 0, 0, 16'h0200, 0, 0);
        for (int i = 0; i < 8; i++)
            check("restore_rf", 64'(rf[i]), 64'((i == 2 && P_SP) ? 16'd256 : 16'hA000 + 16'(i)));

        stall_addr = 16'h0305;
        run_op("save_stall", 1, 0, 16'h0300, 2, 0);
        check("save_stall_cnt", 64'(stall_cnt), 64'd3);

        run_op("save_wrap", 1, 0, 16'hFFFC, 0, 0);
        check("wrap_mem0", 64'(mem[16'h0003]), 64'(rf[7]));

        run_op("both_req", 1, 1, 16'h0400, 0, 1);

        for (int n = 0; n < 10; n++) begin
            bit s;
            logic [15:0] b;
            s = 1'($urandom);
            b = 16'($urandom);
            if (s) for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            else for (int i = 0; i < 8; i++) mem[16'(b + 16'(i))] = 16'($urandom);
            run_op(s ? "rand_save" : "rand_restore", s, 0, b, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
